// File: rtl/mkio_pkg.sv
// Shared definitions for the MKIO remote-terminal receive path.
// Holds the command/status word field positions, the default broadcast address,
// the message sequencer state enum, and small helpers for decoding the word
// count and building the status word.
package mkio_pkg;

  localparam int CMD_ADDR_MSB = 15;
  localparam int CMD_ADDR_LSB = 11;
  localparam int CMD_TR_BIT   = 10;
  localparam int CMD_SA_MSB   = 9;
  localparam int CMD_SA_LSB   = 5;
  localparam int CMD_WC_MSB   = 4;
  localparam int CMD_WC_LSB   = 0;
  localparam int STAT_ME_BIT  = 10;

  localparam logic [4:0] BCAST_ADDR_DEF = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RX_DATA = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  // Command word count field: 0 encodes 32 words.
  function automatic logic [5:0] wc_decode(input logic [4:0] wc);
    return (wc == 5'd0) ? 6'd32 : {1'b0, wc};
  endfunction

  // Status word: RT address on top, message-error bit, everything else zero.
  function automatic logic [15:0] status_word(input logic [4:0] addr, input logic me);
    logic [15:0] s;
    s = '0;
    s[CMD_ADDR_MSB:CMD_ADDR_LSB] = addr;
    s[STAT_ME_BIT] = me;
    return s;
  endfunction

endpackage

// File: rtl/mkio_word_timer.sv
// Inter-word gap timer.
// Ports: clk, reset (sync, active high); clear restarts the count; enable lets
// the count advance; timeout is high while the gap has reached WORD_TIMEOUT-1
// clocks and enable is set.
// The cycle carrying the clearing event counts as clock 0, so the register
// loads 1 on clear: its value is then the number of clocks since that event.
module mkio_word_timer
  import mkio_pkg::*;
#(
  parameter int WORD_TIMEOUT = 400
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int W = $clog2(WORD_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(WORD_TIMEOUT - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (clear)
      cnt <= ONE;
    else if (enable && cnt != LAST)
      cnt <= cnt + ONE;   // saturate so a stalled count never wraps
  end

  assign timeout = enable && (cnt == LAST);

endmodule

// File: rtl/mkio_rt_msg_ctrl.sv
// MKIO remote-terminal message sequencer.
// Decodes command words addressed to this RT (or broadcast), writes following
// data words into the subaddress buffer, supervises the inter-word gap, reports
// each finished message and requests a status word from the transmitter.
// Ports:
//   clk, reset                    clock, sync active-high reset
//   rt_addr                       this terminal's address
//   rx_data/rx_cd/rx_done/
//   rx_parity_error               decoded word from the receiver
//   buf_we/buf_sa/buf_addr/
//   buf_wdata                     data-word write into the subaddress buffer
//   msg_valid + msg_*             end-of-message pulse and message descriptor
//   tx_req/tx_status/tx_ack       status-word handshake with the transmitter
module mkio_rt_msg_ctrl
  import mkio_pkg::*;
#(
  parameter int         WORD_TIMEOUT = 400,
  parameter logic [4:0] BCAST_ADDR   = BCAST_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rt_addr,
  input  logic [15:0] rx_data,
  input  logic        rx_cd,
  input  logic        rx_done,
  input  logic        rx_parity_error,
  output logic        buf_we,
  output logic [4:0]  buf_sa,
  output logic [4:0]  buf_addr,
  output logic [15:0] buf_wdata,
  output logic        msg_valid,
  output logic        msg_tr,
  output logic [4:0]  msg_sa,
  output logic [5:0]  msg_wc,
  output logic        msg_bcast,
  output logic        msg_error,
  output logic        tx_req,
  output logic [15:0] tx_status,
  input  logic        tx_ack
);

  state_t     state;
  logic [5:0] wcnt;
  logic       me;
  logic       timeout;

  logic [4:0] cmd_addr;
  logic       cmd_tr;
  logic       cmd_bcast;
  logic       cmd_hit;
  logic       last_word;
  logic       word_err;

  assign cmd_addr  = rx_data[CMD_ADDR_MSB:CMD_ADDR_LSB];
  assign cmd_tr    = rx_data[CMD_TR_BIT];
  assign cmd_bcast = (cmd_addr == BCAST_ADDR);
  assign cmd_hit   = rx_done && rx_cd && !rx_parity_error &&
                     ((cmd_addr == rt_addr) || cmd_bcast);
  assign last_word = ((wcnt + 6'd1) == msg_wc);
  // Error state of the message including the word arriving this cycle.
  assign word_err  = msg_error || rx_parity_error;

  // Held cleared outside RX_DATA so every message starts with a fresh gap.
  mkio_word_timer #(.WORD_TIMEOUT(WORD_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_done || (state != ST_RX_DATA)),
    .enable  (state == ST_RX_DATA),
    .timeout (timeout)
  );

  assign buf_sa = msg_sa;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      me        <= 1'b0;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      msg_valid <= 1'b0;
      msg_tr    <= 1'b0;
      msg_sa    <= '0;
      msg_wc    <= '0;
      msg_bcast <= 1'b0;
      msg_error <= 1'b0;
      tx_req    <= 1'b0;
      tx_status <= '0;
    end else begin
      buf_we    <= 1'b0;
      msg_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_hit) begin
            msg_tr    <= cmd_tr;
            msg_sa    <= rx_data[CMD_SA_MSB:CMD_SA_LSB];
            msg_wc    <= wc_decode(rx_data[CMD_WC_MSB:CMD_WC_LSB]);
            msg_bcast <= cmd_bcast;
            msg_error <= 1'b0;
            wcnt      <= '0;
            if (!cmd_tr) begin
              state <= ST_RX_DATA;
            end else if (!cmd_bcast) begin
              msg_valid <= 1'b1;
              tx_req    <= 1'b1;
              tx_status <= status_word(rt_addr, me);
              state     <= ST_RESPOND;
            end else begin
              // Broadcast transmit command is illegal: report and stay idle.
              msg_valid <= 1'b1;
              msg_error <= 1'b1;
              me        <= 1'b1;
            end
          end
        end

        ST_RX_DATA: begin
          // rx_done is tested first so a word arriving on the timeout
          // cycle still counts.
          if (rx_done) begin
            if (rx_cd) begin
              // Superseding command aborts the message; the command is dropped.
              msg_valid <= 1'b1;
              msg_error <= 1'b1;
              me        <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              if (!rx_parity_error) begin
                buf_we    <= 1'b1;
                buf_addr  <= wcnt[4:0];
                buf_wdata <= rx_data;
              end
              wcnt      <= wcnt + 6'd1;
              msg_error <= word_err;
              if (last_word) begin
                msg_valid <= 1'b1;
                if (word_err) begin
                  me    <= 1'b1;
                  state <= ST_IDLE;
                end else if (msg_bcast) begin
                  state <= ST_IDLE;
                end else begin
                  tx_req    <= 1'b1;
                  tx_status <= status_word(rt_addr, me);
                  state     <= ST_RESPOND;
                end
              end
            end
          end else if (timeout) begin
            msg_valid <= 1'b1;
            msg_error <= 1'b1;
            me        <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        ST_RESPOND: begin
          if (tx_ack) begin
            tx_req <= 1'b0;
            me     <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
